// File: rtl/npu_dot_pkg.sv
// Shared types and width helpers for the multi-lane NPU dot-product engine.
package npu_dot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } dot_state_e;

  // Width of the sum of LANES signed DATA_W x DATA_W products.
  function automatic int tree_sum_w(input int data_w, input int lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/npu_add_tree.sv
// Registered adder tree: reduces LANES signed products to one sign-extended sum.
module npu_add_tree
  import npu_dot_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  localparam int PROD_W = 2 * DATA_W,
  localparam int SUM_W  = tree_sum_w(DATA_W, LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld_p0,
  input  logic [LANES*PROD_W-1:0] prod_p0,
  output logic                    vld_p1,
  output logic signed [SUM_W-1:0] sum_p1
);

  logic signed [PROD_W-1:0] prod_lane;
  logic signed [SUM_W-1:0]  sum_c;

  always_comb begin
    sum_c     = '0;
    prod_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_lane = $signed(prod_p0[i*PROD_W +: PROD_W]);
      sum_c     = sum_c + SUM_W'(prod_lane);
    end
  end

  // ---- stage 2: registered tree sum ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      sum_p1 <= sum_c;
    end
  end

endmodule

// File: rtl/npu_dot_engine.sv
// Multi-lane signed dot-product engine: multiply, registered tree reduce, accumulate.
// Optional NPU_DOT_RELU_EN clamps a negative final result to zero when relu was set.
module npu_dot_engine
  import npu_dot_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    relu,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES*DATA_W-1:0] weight,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = tree_sum_w(DATA_W, LANES);

  dot_state_e state, state_nxt;

  logic [LEN_W-1:0]          remain;
  logic                      xfer, last_beat, start_acc;
  logic                      vld_p0, vld_p1;
  logic [LANES*PROD_W-1:0]   prod_c, prod_p0;
  logic signed [SUM_W-1:0]   sum_p1;
  logic signed [ACC_W-1:0]   acc_p2, sum_ext, acc_sum;
  logic [ACC_W-1:0]          result_c;
  logic signed [DATA_W-1:0]  a_lane, w_lane;
  logic signed [PROD_W-1:0]  a_ext, w_ext;

  // Signed add overflow: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  assign in_ready  = (state == RUN);
  assign busy      = (state != IDLE);
  assign xfer      = in_valid && in_ready;
  assign last_beat = xfer && (remain == LEN_W'(1));
  assign start_acc = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? HOLD : RUN;
      RUN:     if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (!vld_p0 && !vld_p1) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            remain <= '0;
    else if (start_acc) remain <= len;
    else if (xfer)      remain <= remain - LEN_W'(1);
  end

  always_comb begin
    prod_c = '0;
    a_lane = '0;
    w_lane = '0;
    a_ext  = '0;
    w_ext  = '0;
    for (int i = 0; i < LANES; i++) begin
      a_lane = $signed(in_data[i*DATA_W +: DATA_W]);
      w_lane = $signed(weight[i*DATA_W +: DATA_W]);
      a_ext  = PROD_W'(a_lane);
      w_ext  = PROD_W'(w_lane);
      prod_c[i*PROD_W +: PROD_W] = a_ext * w_ext;
    end
  end

  // ---- stage 1: registered lane products ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      prod_p0 <= '0;
    end else begin
      vld_p0  <= xfer;
      prod_p0 <= prod_c;
    end
  end

  npu_add_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_add_tree (
    .clk     (clk),
    .rst     (rst),
    .vld_p0  (vld_p0),
    .prod_p0 (prod_p0),
    .vld_p1  (vld_p1),
    .sum_p1  (sum_p1)
  );

  assign sum_ext = ACC_W'(sum_p1);
  assign acc_sum = acc_p2 + sum_ext;

  // ---- stage 3: wrapping accumulate with sticky overflow ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2   <= '0;
      overflow <= 1'b0;
    end else if (start_acc) begin
      acc_p2   <= '0;
      overflow <= 1'b0;
    end else if (vld_p1) begin
      acc_p2 <= acc_sum;
      if (add_ovf(acc_p2, sum_ext, acc_sum)) overflow <= 1'b1;
    end
  end

`ifdef NPU_DOT_RELU_EN
  logic relu_q;

  function automatic logic [ACC_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] v,
                                                  input logic en);
    return (en && v[ACC_W-1]) ? '0 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            relu_q <= 1'b0;
    else if (start_acc) relu_q <= relu;
  end

  assign result_c = relu_clamp(acc_p2, relu_q);
`else
  logic unused_relu;
  assign unused_relu = relu;
  assign result_c    = acc_p2;
`endif

  // Result is captured on HOLD entry; a zero-length run never touched the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      if (state != HOLD && state_nxt == HOLD) begin
        out_valid <= 1'b1;
        done      <= 1'b1;
        out_data  <= (state == IDLE) ? '0 : result_c;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_npu_dot_engine.sv
// Scoreboard bench for npu_dot_engine: a 4-lane/32-bit instance and a 1-lane/16-bit instance.
`timescale 1ns/1ps
module tb_npu_dot_engine;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int LEN_W  = 16;
  localparam int ACC16  = 16;

  logic clk = 1'b0;
  logic rst, start, start16, relu, in_valid, out_ready;
  logic [LEN_W-1:0]        len;
  logic [LANES*DATA_W-1:0] in_data, weight;
  logic [DATA_W-1:0]       in_data16, weight16;
  logic in_ready, out_valid, busy, done, overflow;
  logic [ACC_W-1:0] out_data;
  logic in_ready16, out_valid16, busy16, done16, overflow16;
  logic [ACC16-1:0] out_data16;

  int cyc = 0;
  int n_checks = 0;
  int n_fails  = 0;
  int act_a[16][LANES];
  int wt_a[16][LANES];
  longint exp_data_q[$];
  bit     exp_ovf_q[$];

  assign in_data16 = in_data[DATA_W-1:0];
  assign weight16  = weight[DATA_W-1:0];

  npu_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .relu(relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .weight(weight),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  npu_dot_engine #(.LANES(1), .DATA_W(DATA_W), .ACC_W(ACC16), .LEN_W(LEN_W)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .len(len), .relu(relu),
    .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data16), .weight(weight16),
    .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready),
    .busy(busy16), .done(done16), .overflow(overflow16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (m[w-1]) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic logic rdy_of(input bit sel);  return sel ? in_ready16  : in_ready;  endfunction
  function automatic logic ov_of(input bit sel);   return sel ? out_valid16 : out_valid; endfunction
  function automatic logic done_of(input bit sel); return sel ? done16      : done;      endfunction
  function automatic logic busy_of(input bit sel); return sel ? busy16      : busy;      endfunction
  function automatic logic ovf_of(input bit sel);  return sel ? overflow16  : overflow;  endfunction
  function automatic longint data_of(input bit sel);
    return sel ? longint'($signed(out_data16)) : longint'($signed(out_data));
  endfunction

  task automatic load(input int b, input int a0, input int w0, input int ao, input int wo);
    for (int l = 0; l < LANES; l++) begin
      act_a[b][l] = (l == 0) ? a0 : ao;
      wt_a[b][l]  = (l == 0) ? w0 : wo;
    end
  endtask

  task automatic load_ramp();
    for (int b = 0; b < 8; b++) load(b, 2*b + 1, 2*b + 2, 0, 0);
  endtask

  // Reference model: per-beat lane sum added into a W-bit wrapping accumulator.
  task automatic push_expected(input bit sel, input int n, input bit rl);
    longint acc, s, nxt;
    bit ovf;
    int nl, w;
    acc = 0; ovf = 0;
    nl = sel ? 1 : LANES;
    w  = sel ? ACC16 : ACC_W;
    for (int b = 0; b < n; b++) begin
      s = 0;
      for (int l = 0; l < nl; l++) s += longint'(act_a[b][l]) * longint'(wt_a[b][l]);
      nxt = wrap(acc + s, w);
      if (((acc < 0) == (s < 0)) && ((nxt < 0) != (acc < 0))) ovf = 1;
      acc = nxt;
    end
`ifdef NPU_DOT_RELU_EN
    if (rl && acc < 0) acc = 0;
`else
    if (rl) acc = acc;
`endif
    exp_data_q.push_back(acc);
    exp_ovf_q.push_back(ovf);
  endtask

  task automatic run_vec(input bit sel, input int n, input bit rl, input bit gaps, input int hold);
    longint exp_d;
    bit exp_o, saw_rdy;
    int b, k, guard, dones, lat_exp;
    push_expected(sel, n, rl);
    lat_exp = (n == 0) ? 0 : 3;
    @(negedge clk);
    len  = LEN_W'(n);
    relu = rl;
    if (sel) start16 = 1'b1;
    else     start   = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0; start16 = 1'b0;
    b = 0; guard = 0; dones = 0; saw_rdy = 0;
    while (b < n && guard < 4*n + 20) begin
      if (gaps && (guard % 2 == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          in_data[l*DATA_W +: DATA_W] = act_a[b][l][DATA_W-1:0];
          weight[l*DATA_W +: DATA_W]  = wt_a[b][l][DATA_W-1:0];
        end
      end
      if (in_valid && rdy_of(sel)) begin
        b++;
        k = cyc + 1;
      end
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_data = '0; weight = '0;
    check("beats_accepted", b, n);
    guard = 0;
    while (!ov_of(sel) && guard < 20) begin
      if (rdy_of(sel)) saw_rdy = 1;
      dones += done_of(sel);
      guard++;
      @(negedge clk);
    end
    if (rdy_of(sel)) saw_rdy = 1;
    if (n == 0) check("zero_len_in_ready", saw_rdy, 0);
    check("out_valid_seen", ov_of(sel), 1);
    check("latency", cyc - k, lat_exp);
    check("done_first", done_of(sel), 1);
    dones += done_of(sel);
    exp_d = exp_data_q.pop_front();
    exp_o = exp_ovf_q.pop_front();
    check("out_data", data_of(sel), exp_d);
    check("overflow", ovf_of(sel), exp_o);
    check("busy_hold", busy_of(sel), 1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      dones += done_of(sel);
      check("hold_data", data_of(sel), exp_d);
      check("hold_valid", ov_of(sel), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    dones += done_of(sel);
    check("released_valid", ov_of(sel), 0);
    check("idle_busy", busy_of(sel), 0);
    check("done_pulses", dones, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_done"},      done,      0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_overflow"},  overflow,  0);
    check({tag, "_out_data"},  longint'(out_data), 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; start16 = 0; relu = 0; in_valid = 0; out_ready = 0;
    len = '0; in_data = '0; weight = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    load_ramp();
    run_vec(0, 8, 0, 0, 0);
    run_vec(0, 8, 0, 1, 5);

    load(0, -128, -128, -128, -128);
    load(1, -128, -128, -128, -128);
    run_vec(0, 2, 0, 0, 1);
    load(0, 127, -128, 127, -128);
    run_vec(0, 1, 0, 0, 0);

    run_vec(0, 0, 0, 0, 2);

    // Abort a run after three beats with an asynchronous reset.
    load_ramp();
    @(negedge clk);
    len = LEN_W'(8); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        in_data[l*DATA_W +: DATA_W] = act_a[b][l][DATA_W-1:0];
        weight[l*DATA_W +: DATA_W]  = wt_a[b][l][DATA_W-1:0];
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    run_vec(0, 8, 0, 0, 0);

    load(0, -128, -128, 0, 0);
    load(1, -128, -128, 0, 0);
    load(2, -128, -128, 0, 0);
    run_vec(1, 3, 0, 0, 1);
    load(0, 127, -128, 0, 0);
    run_vec(1, 1, 1, 0, 0);
    load(0, 127, -128, 127, -128);
    run_vec(0, 1, 1, 0, 0);
    load(0, 100, 100, 3, 3);
    run_vec(0, 1, 1, 0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 6; b++)
        load(b, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      run_vec(0, 6, 0, r[0], r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/npu_dot_engine.md
# npu_dot_engine

Parametrised multi-lane dot-product engine, the successor to the single-lane NPU multiply-accumulate datapath. Each accepted beat carries LANES signed activation/weight pairs. The engine multiplies the pairs, reduces them through a registered adder tree and accumulates the result over a run-time vector length. It sits between the activation/weight feeders and the NPU result writeback, with valid/ready handshakes on both sides.

## Interface
- LANES, 4: multiply lanes per beat (power of two, ≥1)
- DATA_W, 8: signed width of each activation and weight element
- ACC_W, 32: accumulator/result width (≥ 2*DATA_W+clog2(LANES))
- LEN_W, 16: width of the vector-length field
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- len  in  LEN_W  beats in the run; captured on accepted start
- relu  in  1  clamp negative result to 0 (honoured only with NPU_DOT_RELU_EN)
- in_valid  in  1  beat present on in_data/weight
- in_ready  out  1  engine accepts a beat this cycle
- in_data  in  LANES*DATA_W  activations, lane i at bits [i*DATA_W +: DATA_W]
- weight  in  LANES*DATA_W  weights, same packing
- out_data  out  ACC_W  final dot product
- out_valid  out  1  out_data valid; held until out_ready
- out_ready  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the first cycle out_valid is high
- overflow  out  1  sticky signed accumulator overflow for the current run

## Operation
- FSM states: IDLE, RUN, DRAIN, HOLD.
- IDLE to RUN: start=1 and len≠0. Captures len into the remaining-beats counter, clears the accumulator and overflow, and captures relu.
- IDLE to HOLD: start=1 and len=0. The result is 0, out_valid and done assert next cycle, and overflow is cleared.
- In RUN, in_ready equals 1. A beat transfers when in_valid and in_ready are both high, and the counter then decrements.
- RUN to DRAIN: on the transfer of the last beat. in_ready drops the following cycle.
- DRAIN to HOLD: when the pipeline valid bits are all 0 and the final accumulation has been written.
- HOLD to IDLE: when out_ready=1.
- start is ignored outside IDLE.
- Pipeline stage 1: LANES signed products (2*DATA_W bits each), registered.
- Pipeline stage 2: adder-tree sum (2*DATA_W+clog2(LANES) bits), registered.
- Pipeline stage 3: the sum is sign-extended to ACC_W and added into the accumulator. Addition wraps modulo 2^ACC_W.
- overflow sets when both operands have the same sign and the sum's sign differs. It stays set until the next start.
- in_valid gaps create pipeline bubbles. Bubbles do not change the accumulator.
- Reset in any state: return to IDLE and clear the pipeline, counter, accumulator and all outputs.

## Timing
- Reset values: in_ready=0, out_valid=0, done=0, busy=0, overflow=0, out_data=0.
- in_ready rises the cycle after start is accepted.
- Latency: last beat accepted at edge k gives out_valid=1 and done=1 after edge k+3.
- Throughput: one beat per cycle, with no stalls inside RUN.
- out_data and out_valid stay stable while out_ready=0. out_ready=1 in the first HOLD cycle completes the handshake in that cycle.
- Back-to-back runs: start is accepted in the cycle after the HOLD to IDLE transition.

## Configuration
- NPU_DOT_RELU_EN defined: when the captured relu bit is 1, a negative final result drives out_data=0. overflow is unaffected.
- NPU_DOT_RELU_EN undefined: the relu port is ignored and out_data is always the raw accumulator.

## Structure
- Package npu_dot_pkg holds the state enum (IDLE/RUN/DRAIN/HOLD) and a function computing the tree-sum width from DATA_W and LANES.
- Sub-module npu_add_tree is the registered, parametrised adder tree. Its inputs are LANES products and its output is one registered sum.

## Test plan
- Single-lane vector, NPU regression: LANES=4, len=8, lane 0 activations 1,3,…,15 and weights 2,4,…,16, other lanes 0, continuous valid -> out_data=744 (0x2E8), done one cycle, out_valid 3 cycles after the last beat.
- Backpressure and gaps: same data with in_valid low every other cycle, and out_ready low for 5 cycles -> result 744, out_data stable during the hold, exactly one done pulse.
- Extreme signed values: all lanes -128×-128 for len=2 -> 131072. Then a single-beat run of lanes 127×-128 -> -65024 (0xFFFF0200).
- Zero length: start with len=0 -> out_valid with out_data=0 on the next cycle, in_ready never high.
- Reset mid-run: rst after 3 of 8 beats, then a fresh 8-beat run -> result identical to a clean run, all outputs 0 during reset.
- Overflow and ReLU: with ACC_W=16, accumulate beats summing past 32767 -> overflow=1. With NPU_DOT_RELU_EN defined and relu=1, a negative sum gives out_data=0. With the macro undefined, the same run gives the raw negative value.
